// File: rtl/bist_pkg.sv
// Shared definitions for the ALU self-test loop.
// Used by the LFSR, MISR, the BIST controller and its bench.
package bist_pkg;

   // Controller state encoding
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      FLUSH   = 3'd3,
      COMPARE = 3'd4,
      DONE    = 3'd5
   } bist_state_t;

   // Signature width of the MISR
   localparam int SIG_W_DEF = 74;

   // Signature expected after a full 255-pattern run through the ALU
   localparam logic [SIG_W_DEF-1:0] GOLDEN_DEF = 74'h1347fb692ca37a6c70c;

endpackage

// File: rtl/bist_controller_if.sv
// Handshake / status bundle between the BIST controller and the rest of the
// self-test loop. The controller takes the slave modport.
interface bist_controller_if #(
   parameter int SIG_W = 74,
   parameter int CNT_W = 8
);
   logic             start;
   logic [SIG_W-1:0] misr_sig;
   logic             tpg_en;
   logic             misr_clear;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] pattern_cnt;
   logic [SIG_W-1:0] sig_capt;

   modport master (
      output start, misr_sig,
      input  tpg_en, misr_clear, busy, done, pass, pattern_cnt, sig_capt
   );

   modport slave (
      input  start, misr_sig,
      output tpg_en, misr_clear, busy, done, pass, pattern_cnt, sig_capt
   );
endinterface

// File: rtl/bist_pattern_counter.sv
// Pattern counter for the BIST run: synchronous clear, count enable,
// terminal flag one pattern before the end, saturates at NUM_PATTERNS.
module bist_pattern_counter #(
   parameter int NUM_PATTERNS = 255,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);
   localparam logic [CNT_W-1:0] TOP  = CNT_W'(NUM_PATTERNS);

   // Count applied patterns; never wrap past NUM_PATTERNS
   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (en && cnt != TOP)
         cnt <= cnt + CNT_W'(1);
   end

   // High while the last pattern of the run is being applied
   assign tc = (cnt == LAST);
endmodule

// File: rtl/bist_controller.sv
// BIST sequencer and signature checker for the ALU self-test loop.
// CLEAR -> RUN (NUM_PATTERNS cycles) -> FLUSH (FLUSH_CYC cycles) -> COMPARE
// -> DONE. Define BIST_CAPTURE_EN to keep the final signature in sig_capt.
module bist_controller
   import bist_pkg::*;
#(
   parameter int               SIG_W        = SIG_W_DEF,
   parameter int               NUM_PATTERNS = 255,
   parameter int               FLUSH_CYC    = 1,
   parameter logic [SIG_W-1:0] GOLDEN       = GOLDEN_DEF
) (
   input logic               clk,
   input logic               reset,
   bist_controller_if.slave  bus
);
   localparam int CNT_W = $clog2(NUM_PATTERNS + 1);
   localparam int FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
   localparam logic [FL_W-1:0] FL_LOAD = FL_W'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

   bist_state_t      state;
   logic [FL_W-1:0]  fl_cnt;
   logic             tpg_en, misr_clear, busy, done, pass;
   logic [CNT_W-1:0] cnt;
   logic             tc;
   logic             start_ok;

   // A new run is accepted only from IDLE or DONE; start while busy is dropped
   assign start_ok = bus.start && (state == IDLE || state == DONE);

   bist_pattern_counter #(
      .NUM_PATTERNS (NUM_PATTERNS),
      .CNT_W        (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (start_ok),
      .en    (tpg_en),
      .cnt   (cnt),
      .tc    (tc)
   );

   // Sequencer with registered outputs, each set on the edge entering its state
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fl_cnt     <= '0;
         tpg_en     <= 1'b0;
         misr_clear <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start_ok) begin
               state      <= CLEAR;
               misr_clear <= 1'b1;
               busy       <= 1'b1;
               done       <= 1'b0;
               pass       <= 1'b0;
            end
            CLEAR: begin
               state      <= RUN;
               misr_clear <= 1'b0;
               tpg_en     <= 1'b1;
            end
            RUN: if (tc) begin
               tpg_en <= 1'b0;
               fl_cnt <= FL_LOAD;
               state  <= (FLUSH_CYC == 0) ? COMPARE : FLUSH;
            end
            FLUSH: begin
               if (fl_cnt == '0) state <= COMPARE;
               else              fl_cnt <= fl_cnt - FL_W'(1);
            end
            COMPARE: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (bus.misr_sig == GOLDEN);
            end
            default: begin
               state      <= IDLE;
               tpg_en     <= 1'b0;
               misr_clear <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
               pass       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tpg_en      = tpg_en;
   assign bus.misr_clear  = misr_clear;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.pass        = pass;
   assign bus.pattern_cnt = cnt;

`ifdef BIST_CAPTURE_EN
   logic [SIG_W-1:0] sig_capt_q;

   // Debug copy of the signature seen on the compare edge
   always_ff @(posedge clk) begin
      if (reset || start_ok)
         sig_capt_q <= '0;
      else if (state == COMPARE)
         sig_capt_q <= bus.misr_sig;
   end

   assign bus.sig_capt = sig_capt_q;
`else
   assign bus.sig_capt = '0;
`endif
endmodule
